// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op encodings and the
// ID/EX register layout with its bubble value.
package riscv_pipe_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'hA;

  // Everything the EX stage needs from one decoded instruction.
  typedef struct packed {
    logic                valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic                alu_src;
    logic [XLEN-1:0]     pc_4;
    logic [REG_AW-1:0]   rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } id_ex_t;

  // A bubble is an invalid ADD with no side effects and all data zeroed.
  localparam id_ex_t ID_EX_BUBBLE = '{alu_op: ALU_ADD, default: '0};

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: picks the youngest in-flight
// result targeting that register, else the value latched at ID/EX capture.
module fwd_mux
  import riscv_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [XLEN-1:0]   i_rs_data,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]   i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]   i_memwb_result,
  output logic [XLEN-1:0]   o_value
);

  // Select operand source; EX/MEM is younger so it wins over MEM/WB, and x0 is hard zero.
  always_comb begin
    // NOTE: assign a default first so every path drives o_value and no latch is inferred.
    o_value = i_rs_data;
    if (i_rs_addr == '0) begin
      o_value = '0;
    end else if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_rs_addr)) begin
      o_value = i_exmem_result;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_rs_addr)) begin
      o_value = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling,
// regfile write-through bypass at capture and EX-side operand forwarding.
module id_ex_stage
  import riscv_pipe_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic [REG_AW-1:0]   id_rs1_addr_i,
  input  logic [REG_AW-1:0]   id_rs2_addr_i,
  input  logic                id_uses_rs1_i,
  input  logic                id_uses_rs2_i,
  input  logic [XLEN-1:0]     id_rs1_data_i,
  input  logic [XLEN-1:0]     id_rs2_data_i,
  input  logic [XLEN-1:0]     id_imm_i,
  input  logic                id_alu_src_i,
  input  logic [XLEN-1:0]     id_pc_4_i,
  input  logic [REG_AW-1:0]   id_rd_addr_i,
  input  logic                id_reg_write_i,
  input  logic                id_mem_read_i,
  input  logic                id_mem_write_i,
  input  logic                flush_i,
  input  logic                hold_i,
  input  logic                exmem_reg_write_i,
  input  logic [REG_AW-1:0]   exmem_rd_i,
  input  logic [XLEN-1:0]     exmem_result_i,
  input  logic                memwb_reg_write_i,
  input  logic [REG_AW-1:0]   memwb_rd_i,
  input  logic [XLEN-1:0]     memwb_result_i,
  output logic                ex_valid_o,
  output logic [ALU_OP_W-1:0] ALU_Operation_o,
  output logic [XLEN-1:0]     A_o,
  output logic [XLEN-1:0]     B_o,
  output logic [XLEN-1:0]     PC_4_o,
  output logic [XLEN-1:0]     ex_store_data_o,
  output logic [REG_AW-1:0]   ex_rd_o,
  output logic                ex_reg_write_o,
  output logic                ex_mem_read_o,
  output logic                ex_mem_write_o,
  output logic                stall_o
);

  id_ex_t            r_ex;
  id_ex_t            w_next;
  logic              w_load_use;
  logic              w_bypass_rs1;
  logic              w_bypass_rs2;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;

  // A register written back this cycle is not yet visible in the regfile read.
  assign w_bypass_rs1 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs1_addr_i);
  assign w_bypass_rs2 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs2_addr_i);

  // Assemble the next EX slot from ID fields; an empty ID slot carries no side effects.
  always_comb begin
    w_next           = ID_EX_BUBBLE;
    w_next.valid     = id_valid_i;
    w_next.alu_op    = id_alu_op_i;
    w_next.rs1       = id_rs1_addr_i;
    w_next.rs2       = id_rs2_addr_i;
    w_next.rs1_data  = w_bypass_rs1 ? memwb_result_i : id_rs1_data_i;
    w_next.rs2_data  = w_bypass_rs2 ? memwb_result_i : id_rs2_data_i;
    w_next.imm       = id_imm_i;
    w_next.alu_src   = id_alu_src_i;
    w_next.pc_4      = id_pc_4_i;
    w_next.rd        = id_rd_addr_i;
    w_next.reg_write = id_valid_i && id_reg_write_i;
    w_next.mem_read  = id_valid_i && id_mem_read_i;
    w_next.mem_write = id_valid_i && id_mem_write_i;
  end

  // A load in EX cannot forward its data yet, so a dependent ID instruction waits one cycle.
  assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) && id_valid_i &&
                      ((id_uses_rs1_i && (id_rs1_addr_i == r_ex.rd)) ||
                       (id_uses_rs2_i && (id_rs2_addr_i == r_ex.rd)));

  // A flushed ID instruction is dead, so it never needs to stall IF/ID.
  assign stall_o = (w_load_use && !flush_i) || hold_i;

  // Pipeline register: reset > hold > flush/load-use bubble > capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      r_ex <= ID_EX_BUBBLE;
    end else if (hold_i) begin
      r_ex <= r_ex;
    end else if (flush_i || w_load_use) begin
      r_ex <= ID_EX_BUBBLE;
    end else begin
      r_ex <= w_next;
    end
  end

  fwd_mux u_fwd_rs1 (
    .i_rs_addr         (r_ex.rs1),
    .i_rs_data         (r_ex.rs1_data),
    .i_exmem_reg_write (exmem_reg_write_i),
    .i_exmem_rd        (exmem_rd_i),
    .i_exmem_result    (exmem_result_i),
    .i_memwb_reg_write (memwb_reg_write_i),
    .i_memwb_rd        (memwb_rd_i),
    .i_memwb_result    (memwb_result_i),
    .o_value           (w_fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .i_rs_addr         (r_ex.rs2),
    .i_rs_data         (r_ex.rs2_data),
    .i_exmem_reg_write (exmem_reg_write_i),
    .i_exmem_rd        (exmem_rd_i),
    .i_exmem_result    (exmem_result_i),
    .i_memwb_reg_write (memwb_reg_write_i),
    .i_memwb_rd        (memwb_rd_i),
    .i_memwb_result    (memwb_result_i),
    .o_value           (w_fwd_rs2)
  );

  assign ex_valid_o      = r_ex.valid;
  assign ALU_Operation_o = r_ex.alu_op;
  assign A_o             = w_fwd_rs1;
  assign B_o             = r_ex.alu_src ? r_ex.imm : w_fwd_rs2;
  assign PC_4_o          = r_ex.pc_4;
  assign ex_store_data_o = w_fwd_rs2;
  assign ex_rd_o         = r_ex.rd;
  assign ex_reg_write_o  = r_ex.reg_write;
  assign ex_mem_read_o   = r_ex.mem_read;
  assign ex_mem_write_o  = r_ex.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use,
// flush, hold and capture bypass with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid_i;
  logic [3:0]  id_alu_op_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_4_i;
  logic        id_alu_src_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_reg_write_i, id_mem_read_i, id_mem_write_i;
  logic        flush_i, hold_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic        ex_valid_o;
  logic [3:0]  ALU_Operation_o;
  logic [31:0] A_o, B_o, PC_4_o, ex_store_data_o;
  logic [4:0]  ex_rd_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, stall_o;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage dut (
    .clk               (clk),
    .reset             (reset),
    .id_valid_i        (id_valid_i),
    .id_alu_op_i       (id_alu_op_i),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .id_rs1_data_i     (id_rs1_data_i),
    .id_rs2_data_i     (id_rs2_data_i),
    .id_imm_i          (id_imm_i),
    .id_alu_src_i      (id_alu_src_i),
    .id_pc_4_i         (id_pc_4_i),
    .id_rd_addr_i      (id_rd_addr_i),
    .id_reg_write_i    (id_reg_write_i),
    .id_mem_read_i     (id_mem_read_i),
    .id_mem_write_i    (id_mem_write_i),
    .flush_i           (flush_i),
    .hold_i            (hold_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_result_i    (memwb_result_i),
    .ex_valid_o        (ex_valid_o),
    .ALU_Operation_o   (ALU_Operation_o),
    .A_o               (A_o),
    .B_o               (B_o),
    .PC_4_o            (PC_4_o),
    .ex_store_data_o   (ex_store_data_o),
    .ex_rd_o           (ex_rd_o),
    .ex_reg_write_o    (ex_reg_write_o),
    .ex_mem_read_o     (ex_mem_read_o),
    .ex_mem_write_o    (ex_mem_write_o),
    .stall_o           (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_fwd();
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_result_i = 0;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic src, input logic [31:0] imm, input logic [31:0] pc4);
    id_valid_i = 1; id_alu_op_i = op; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_rs1_data_i = d1; id_rs2_data_i = d2;
    id_rd_addr_i = rd; id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
    id_alu_src_i = src; id_imm_i = imm; id_pc_4_i = pc4;
  endtask

  initial begin
    reset = 0; flush_i = 0; hold_i = 0;
    clear_fwd();
    // Reset held two cycles with a live ID instruction.
    set_id(4'h3, 5'd1, 5'd2, 1, 1, 32'h5, 32'h6, 5'd4, 1, 1, 1, 0, 32'h0, 32'h44);
    tick(); tick();
    check("rst_valid", {31'b0, ex_valid_o}, 32'h0);
    check("rst_aluop", {28'b0, ALU_Operation_o}, 32'h0);
    check("rst_A", A_o, 32'h0);
    check("rst_B", B_o, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_ctrl", {29'b0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}, 32'h0);
    reset = 1;

    // ADD x6,x5,x5 with stale regfile value 1.
    set_id(4'h0, 5'd5, 5'd5, 1, 1, 32'h1, 32'h1, 5'd6, 1, 0, 0, 0, 32'h0, 32'h104);
    tick();
    check("cap_valid", {31'b0, ex_valid_o}, 32'h1);
    check("cap_pc4", PC_4_o, 32'h104);
    check("cap_rd", {27'b0, ex_rd_o}, 32'd6);
    check("cap_A_latched", A_o, 32'h1);
    exmem_reg_write_i = 1; exmem_rd_i = 5'd5; exmem_result_i = 32'h10;
    settle();
    check("exmem_A", A_o, 32'h10);
    check("exmem_B", B_o, 32'h10);
    memwb_reg_write_i = 1; memwb_rd_i = 5'd5; memwb_result_i = 32'h20;
    settle();
    check("prio_A", A_o, 32'h10);
    check("prio_B", B_o, 32'h10);
    exmem_reg_write_i = 0;
    settle();
    check("memwb_A", A_o, 32'h20);
    clear_fwd();

    // Reads of x0 with alu_src=1; EX/MEM claims rd=x0 with 0xFF.
    set_id(4'h0, 5'd0, 5'd2, 1, 1, 32'h0, 32'h22, 5'd9, 1, 0, 1, 1, 32'hFFFF_F800, 32'h108);
    tick();
    exmem_reg_write_i = 1; exmem_rd_i = 5'd0; exmem_result_i = 32'hFF;
    settle();
    check("x0_A", A_o, 32'h0);
    check("imm_B", B_o, 32'hFFFF_F800);
    check("store_latched", ex_store_data_o, 32'h22);
    check("store_ctrl", {31'b0, ex_mem_write_o}, 32'h1);
    exmem_rd_i = 5'd2; exmem_result_i = 32'h99;
    settle();
    check("store_fwd", ex_store_data_o, 32'h99);
    check("imm_B_kept", B_o, 32'hFFFF_F800);
    clear_fwd();

    // LW x7 into EX, then dependent ADD x8,x7,x1.
    set_id(4'h0, 5'd1, 5'd0, 1, 0, 32'h1000, 32'h0, 5'd7, 1, 1, 0, 1, 32'h4, 32'h10C);
    tick();
    set_id(4'h0, 5'd7, 5'd1, 1, 1, 32'h0, 32'h5, 5'd8, 1, 0, 0, 0, 32'h0, 32'h110);
    settle();
    check("lu_stall", {31'b0, stall_o}, 32'h1);
    tick();
    check("lu_bubble_valid", {31'b0, ex_valid_o}, 32'h0);
    check("lu_bubble_ctrl", {29'b0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}, 32'h0);
    check("lu_stall_once", {31'b0, stall_o}, 32'h0);
    exmem_reg_write_i = 1; exmem_rd_i = 5'd7; exmem_result_i = 32'h1004;
    tick();
    clear_fwd();
    memwb_reg_write_i = 1; memwb_rd_i = 5'd7; memwb_result_i = 32'hCAFE;
    settle();
    check("lu_valid", {31'b0, ex_valid_o}, 32'h1);
    check("lu_rd", {27'b0, ex_rd_o}, 32'd8);
    check("lu_A_memwb", A_o, 32'hCAFE);
    check("lu_B", B_o, 32'h5);
    clear_fwd();

    // LW x7 again; dependence through an unused field must not stall.
    set_id(4'h0, 5'd1, 5'd0, 1, 0, 32'h1000, 32'h0, 5'd7, 1, 1, 0, 1, 32'h4, 32'h114);
    tick();
    set_id(4'h0, 5'd7, 5'd1, 0, 1, 32'h0, 32'h5, 5'd8, 1, 0, 0, 0, 32'h0, 32'h118);
    settle();
    check("lu_unused_rs1", {31'b0, stall_o}, 32'h0);
    id_rs2_addr_i = 5'd7;
    settle();
    check("lu_rs2", {31'b0, stall_o}, 32'h1);
    flush_i = 1;
    settle();
    check("flush_lu_stall", {31'b0, stall_o}, 32'h0);
    tick();
    flush_i = 0;
    check("flush_valid", {31'b0, ex_valid_o}, 32'h0);
    check("flush_rw", {31'b0, ex_reg_write_o}, 32'h0);

    // Hold for three cycles with flush asserted during the hold.
    set_id(4'h1, 5'd3, 5'd4, 1, 1, 32'h11, 32'h22, 5'd9, 1, 0, 0, 0, 32'h0, 32'h200);
    tick();
    check("pre_hold_op", {28'b0, ALU_Operation_o}, 32'h1);
    set_id(4'h2, 5'd5, 5'd6, 1, 1, 32'h33, 32'h44, 5'd10, 1, 0, 0, 0, 32'h0, 32'h300);
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_stall", {31'b0, stall_o}, 32'h1);
      if (i > 0) flush_i = 1;
      tick();
      check("hold_op", {28'b0, ALU_Operation_o}, 32'h1);
      check("hold_pc4", PC_4_o, 32'h200);
      check("hold_rd", {27'b0, ex_rd_o}, 32'd9);
      check("hold_valid", {31'b0, ex_valid_o}, 32'h1);
    end
    hold_i = 0;
    settle();
    check("release_stall", {31'b0, stall_o}, 32'h0);
    tick();
    flush_i = 0;
    check("release_flush_valid", {31'b0, ex_valid_o}, 32'h0);
    check("release_flush_rw", {31'b0, ex_reg_write_o}, 32'h0);

    // Capture bypass: MEM/WB writes x3 while ID reads stale x3.
    set_id(4'h0, 5'd3, 5'd0, 1, 0, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 32'h0, 32'h120);
    memwb_reg_write_i = 1; memwb_rd_i = 5'd3; memwb_result_i = 32'hABCD;
    tick();
    clear_fwd();
    settle();
    check("bypass_A", A_o, 32'hABCD);

    // Reset during hold: reset wins, stall follows hold only.
    hold_i = 1; reset = 0;
    tick();
    check("rst_hold_valid", {31'b0, ex_valid_o}, 32'h0);
    check("rst_hold_stall", {31'b0, stall_o}, 32'h1);
    hold_i = 0;
    settle();
    check("rst_nohold_stall", {31'b0, stall_o}, 32'h0);
    reset = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
